// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetch unit: one outstanding arbiter request feeding a small PC-tagged buffer
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_req,
    input  logic                  fetch_ack,
    input  logic [DATA_WIDTH-1:0] fetch_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    output logic                  fetch_busy,
    output logic [31:0]           fetched_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                state;
    logic                  discard;
    logic [ADDR_WIDTH-1:0] pc;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      occ;

    logic                  has_room;
    logic                  can_issue;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redirect_target;

    assign has_room        = (occ < CNT_W'(FIFO_DEPTH));
    assign pop             = (occ != '0) && instr_ready;
    // A redirect on the ack edge kills the response just like one seen earlier in WAIT.
    assign push            = (state == S_WAIT) && fetch_ack && !discard && !redirect_valid;
    assign can_issue       = enable && !fetch_ack && has_room && !redirect_valid;
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fetch_req  <= 1'b0;
            fetch_addr <= RESET_PC;
            discard    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (can_issue) begin
                        state      <= S_WAIT;
                        fetch_req  <= 1'b1;
                        fetch_addr <= pc;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                    if (fetch_ack) begin
                        state     <= S_RELEASE;
                        fetch_req <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (!fetch_ack) begin
                        state   <= S_IDLE;
                        discard <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    fetch_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            fetched_count <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (push) begin
                pc <= pc + ADDR_WIDTH'(4);
            end
            if (push) begin
                fetched_count <= fetched_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + CNT_W'(1);
            end else if (pop && !push) begin
                occ <= occ - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= fetch_rdata;
            mem_pc[wr_ptr]   <= pc;
        end
    end

    // Head fields read as zero when empty so reset clears them without resetting the storage.
    assign instr_valid = (occ != '0);
    assign instr_data  = instr_valid ? mem_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr] : '0;
    assign fetch_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          fetch_ack = 1'b0;
    logic [DW-1:0] fetch_rdata = '0;
    logic          instr_ready = 1'b0;

    logic [AW-1:0] fetch_addr, instr_pc, d2_fetch_addr, d2_instr_pc;
    logic [DW-1:0] instr_data, d2_instr_data;
    logic          fetch_req, instr_valid, fetch_busy;
    logic          d2_fetch_req, d2_instr_valid, d2_fetch_busy;
    logic [31:0]   fetched_count, d2_fetched_count;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_addr(fetch_addr), .fetch_req(fetch_req),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_busy(fetch_busy), .fetched_count(fetched_count)
    );

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_addr(d2_fetch_addr), .fetch_req(d2_fetch_req),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .instr_valid(d2_instr_valid), .instr_data(d2_instr_data), .instr_pc(d2_instr_pc),
        .instr_ready(instr_ready), .fetch_busy(d2_fetch_busy), .fetched_count(d2_fetched_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: buffer as a queue, request lifecycle as protocol flags.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        m_q[$];
    logic [AW-1:0] m_pc, m_addr;
    logic [31:0]   m_cnt;
    bit            m_req, m_hold, m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc = '0; m_addr = '0; m_cnt = '0;
            m_req = 0; m_hold = 0; m_drop = 0;
        end else begin
            bit do_pop, do_push, nxt_drop;
            do_pop   = (m_q.size() != 0) && instr_ready;
            do_push  = 0;
            nxt_drop = m_drop;
            if (m_req) begin
                if (redirect_valid) nxt_drop = 1;
                if (fetch_ack) begin
                    m_req   = 0;
                    m_hold  = 1;
                    do_push = !m_drop && !redirect_valid;
                end
            end else if (m_hold) begin
                if (!fetch_ack) begin
                    m_hold   = 0;
                    nxt_drop = 0;
                end
            end else if (enable && !fetch_ack && m_q.size() < DEPTH && !redirect_valid) begin
                m_req  = 1;
                m_addr = m_pc;
            end
            m_drop = nxt_drop;
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc & ~32'h3;
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (do_push) begin
                    m_q.push_back({m_pc, fetch_rdata});
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end
            end
        end
    end

    // Arbiter: acks the model's outstanding request after a latency, holds ack for a number of cycles.
    int            wait_left = 0, ack_left = 0, arb_lat = 1, arb_hold = 1;
    bit            arb_rand = 0;
    logic [DW-1:0] arb_data = 32'h13;

    always @(negedge clk) begin
        if (ack_left > 0) begin
            ack_left--;
            if (ack_left == 0) begin
                fetch_ack = 1'b0;
                wait_left = arb_rand ? int'($urandom_range(0, 3)) : arb_lat;
            end
        end else if (!m_req) begin
            wait_left = arb_rand ? int'($urandom_range(0, 3)) : arb_lat;
        end else if (wait_left > 0) begin
            wait_left--;
        end else begin
            fetch_ack   = 1'b1;
            fetch_rdata = arb_rand ? $urandom : arb_data;
            ack_left    = arb_rand ? int'($urandom_range(1, 3)) : arb_hold;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("fetch_req", 64'(fetch_req), 64'(m_req));
            chk("fetch_addr", 64'(fetch_addr), 64'(m_addr));
            chk("fetch_busy", 64'(fetch_busy), 64'(m_req || m_hold));
            chk("instr_valid", 64'(instr_valid), 64'(m_q.size() != 0));
            chk("fetched_count", 64'(fetched_count), 64'(m_cnt));
            if (m_q.size() != 0) begin
                chk("instr_pc", 64'(instr_pc), 64'(m_q[0].pc));
                chk("instr_data", 64'(instr_data), 64'(m_q[0].data));
            end
        end
    end

    function automatic logic cur(input int kind);
        case (kind)
            0:       return fetch_req;
            1:       return instr_valid;
            default: return fetch_busy;
        endcase
    endfunction

    task automatic wait_cond(input string name, input int kind, input logic val, output int n);
        n = 0;
        while (cur(kind) !== val && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL %s timeout actual=%0b required=%0b", name, cur(kind), val);
        end
    endtask

    task automatic wait_cnt(input string name, input logic [31:0] target);
        int n = 0;
        while (fetched_count !== target && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL %s timeout actual=%0d required=%0d", name, fetched_count, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit saw;
        enable = 1'b1;
        instr_ready = 1'b1;
        #1 rst_n = 1'b0;
        chk_on = 1;
        #2;
        chk("rst_req", 64'(fetch_req), 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_count", 64'(fetched_count), 64'(0));
        chk("rst_addr", 64'(fetch_addr), 64'(32'h0));
        chk("rst_data", 64'(instr_data), 64'(0));
        chk("rst_busy", 64'(fetch_busy), 64'(0));
        chk("rst_addr_wrap", 64'(d2_fetch_addr), 64'(32'hFFFF_FFFC));
        @(negedge clk);
        #2 rst_n = 1'b1;

        // First fetch after reset, and PC wrap on the second instance.
        wait_cond("first_req", 0, 1'b1, n);
        chk("first_addr", 64'(fetch_addr), 64'(32'h0));
        chk("wrap_first_addr", 64'(d2_fetch_addr), 64'(32'hFFFF_FFFC));
        wait_cond("first_valid", 1, 1'b1, n);
        chk("first_pc", 64'(instr_pc), 64'(32'h0));
        chk("first_data", 64'(instr_data), 64'(32'h13));
        chk("first_count", 64'(fetched_count), 64'(1));
        chk("wrap_first_pc", 64'(d2_instr_pc), 64'(32'hFFFF_FFFC));
        wait_cond("second_req", 0, 1'b1, n);
        chk("second_addr", 64'(fetch_addr), 64'(32'h4));
        chk("wrap_second_addr", 64'(d2_fetch_addr), 64'(32'h0));

        // Fill the buffer with no consumer, then free one slot.
        instr_ready = 1'b0;
        enable = 1'b0;
        wait_cond("idle_b", 2, 1'b0, n);
        do_reset();
        enable = 1'b1;
        wait_cnt("fill", 32'd4);
        chk("full_head_pc", 64'(instr_pc), 64'(32'h0));
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (fetch_req) saw = 1;
        end
        chk("full_no_req", 64'(saw), 64'(0));
        arb_lat = 3;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("pop_head_pc", 64'(instr_pc), 64'(32'h4));
        wait_cond("req_after_pop", 0, 1'b1, n);
        chk("req_after_pop_addr", 64'(fetch_addr), 64'(32'h10));

        // Redirect while the request is outstanding.
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        arb_data = 32'hDEAD_BEEF;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_flush", 64'(instr_valid), 64'(0));
        chk("redir_count", 64'(fetched_count), 64'(4));
        wait_cond("redir_req_low", 0, 1'b0, n);
        wait_cond("redir_req", 0, 1'b1, n);
        chk("redir_addr", 64'(fetch_addr), 64'(32'h100));
        chk("redir_no_push", 64'(fetched_count), 64'(4));
        chk("redir_empty", 64'(instr_valid), 64'(0));

        // enable=0 still completes the outstanding fetch; then redirect in IDLE.
        enable = 1'b0;
        wait_cond("idle_d", 2, 1'b0, n);
        chk("dis_count", 64'(fetched_count), 64'(5));
        chk("dis_head_pc", 64'(instr_pc), 64'(32'h100));
        chk("dis_head_data", 64'(instr_data), 64'(32'hDEAD_BEEF));
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        enable = 1'b1;
        chk("idle_redir_flush", 64'(instr_valid), 64'(0));
        wait_cond("idle_redir_req", 0, 1'b1, n);
        chk("idle_redir_addr", 64'(fetch_addr), 64'(32'h200));

        // Ack held three cycles: one push, reissue only after ack drops.
        arb_hold = 3;
        arb_lat = 1;
        instr_ready = 1'b1;
        wait_cond("hold_req_low", 0, 1'b0, n);
        wait_cond("hold_req", 0, 1'b1, n);
        chk("hold_gap", 64'(n), 64'(4));
        chk("hold_count", 64'(fetched_count), 64'(6));
        chk("hold_addr", 64'(fetch_addr), 64'(32'h204));

        // Asynchronous reset with a request outstanding and two entries buffered.
        arb_hold = 1;
        instr_ready = 1'b0;
        do_reset();
        wait_cnt("fill2", 32'd2);
        arb_lat = 8;
        wait_cond("pre_rst_req", 0, 1'b1, n);
        chk("pre_rst_valid", 64'(instr_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", 64'(fetch_req), 64'(0));
        chk("async_valid", 64'(instr_valid), 64'(0));
        chk("async_count", 64'(fetched_count), 64'(0));
        chk("async_busy", 64'(fetch_busy), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic against the model.
        arb_rand = 1;
        repeat (4000) begin
            @(negedge clk);
            enable = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        redirect_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
